// File: rtl/risc_pkg.sv
// Shared constants and state encoding for the risc8 memory-mapped UART transmitter.
// Optional parity stage controlled by macro RISC8_UART_PARITY_EN.
package risc_pkg;

  localparam logic [7:0] UART_DATA_ADDR = 8'hFF;
  localparam logic [7:0] UART_STAT_ADDR = 8'hFE;

  localparam int UST_BUSY  = 0;
  localparam int UST_FULL  = 1;
  localparam int UST_EMPTY = 2;
  localparam int UST_OVF   = 3;

`ifdef RISC8_UART_PARITY_EN
  typedef enum logic [2:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_PARITY,
    UART_STOP
  } e_uart_state;
`else
  typedef enum logic [2:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } e_uart_state;
`endif

endpackage

// File: rtl/risc8_sync_fifo.sv
// Synchronous FIFO with explicit occupancy count; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module risc8_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Depth is a power of two, so pointer overflow gives the modulo wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/risc8_uart_tx.sv
// Memory-mapped 8N1 UART transmitter snooping risc8 CPU stores, with status register.
// Define RISC8_UART_PARITY_EN to insert an even-parity bit between data and stop.
module risc8_uart_tx
  import risc_pkg::*;
#(
  parameter int         BAUD_DIV   = 434,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] DATA_ADDR  = UART_DATA_ADDR,
  parameter logic [7:0] STAT_ADDR  = UART_STAT_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mem_addr,
  input  logic       mem_wr_en,
  input  logic [7:0] mem_wr_data,
  output logic [7:0] rd_data,
  output logic       rd_hit,
  output logic       tx
);

  localparam int          CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);

  e_uart_state       state;
  logic [15:0]       baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic              ovf;
  logic              enq_req;
  logic              stat_wr;
  logic              baud_done;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [7:0]        fifo_dout;
  logic [7:0]        status;

  assign enq_req   = mem_wr_en && (mem_addr == DATA_ADDR);
  assign stat_wr   = mem_wr_en && (mem_addr == STAT_ADDR);
  assign baud_done = (baud_cnt == 16'd0);
  assign pop       = !fifo_empty &&
                     ((state == UART_IDLE) || ((state == UART_STOP) && baud_done));

  risc8_sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (enq_req),
    .pop   (pop),
    .din   (mem_wr_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A full FIFO still accepts the byte when the FSM pops in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (stat_wr) begin
      ovf <= 1'b0;
    end else if (enq_req && fifo_full && !pop) begin
      ovf <= 1'b1;
    end
  end

  always_comb begin
    status            = '0;
    status[UST_BUSY]  = (state != UART_IDLE);
    status[UST_FULL]  = fifo_full;
    status[UST_EMPTY] = fifo_empty;
    status[UST_OVF]   = ovf;
    status[7:4]       = 4'(fifo_count);
  end

  assign rd_hit  = (mem_addr == DATA_ADDR) || (mem_addr == STAT_ADDR);
  assign rd_data = (mem_addr == STAT_ADDR) ? status : 8'h00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= UART_IDLE;
      baud_cnt <= 16'd0;
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
      tx       <= 1'b1;
    end else begin
      case (state)
        UART_IDLE: begin
          if (pop) begin
            shreg    <= fifo_dout;
            bit_cnt  <= 3'd0;
            baud_cnt <= BAUD_RELOAD;
            tx       <= 1'b0;
            state    <= UART_START;
          end
        end
        UART_START: begin
          if (baud_done) begin
            baud_cnt <= BAUD_RELOAD;
            tx       <= shreg[0];
            state    <= UART_DATA;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        UART_DATA: begin
          if (baud_done) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_cnt == 3'd7) begin
`ifdef RISC8_UART_PARITY_EN
              tx    <= ^shreg;
              state <= UART_PARITY;
`else
              tx    <= 1'b1;
              state <= UART_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shreg[bit_cnt + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
`ifdef RISC8_UART_PARITY_EN
        UART_PARITY: begin
          if (baud_done) begin
            baud_cnt <= BAUD_RELOAD;
            tx       <= 1'b1;
            state    <= UART_STOP;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
`endif
        UART_STOP: begin
          // Chain straight into the next start bit when more data is queued.
          if (baud_done) begin
            if (pop) begin
              shreg    <= fifo_dout;
              bit_cnt  <= 3'd0;
              baud_cnt <= BAUD_RELOAD;
              tx       <= 1'b0;
              state    <= UART_START;
            end else begin
              state <= UART_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          state <= UART_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_risc8_uart_tx.sv
// Directed bench for risc8_uart_tx: stores drive a scoreboard queue, a line monitor
// decodes frames cycle by cycle and pops the expected bytes.
module tb_risc8_uart_tx;

  localparam int BAUD = 4;
`ifdef RISC8_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * BAUD;
  localparam logic [7:0] A_DATA = 8'hFF;
  localparam logic [7:0] A_STAT = 8'hFE;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] mem_addr = 8'h00;
  logic       mem_wr_en = 1'b0;
  logic [7:0] mem_wr_data = 8'h00;
  logic [7:0] rd_data;
  logic       rd_hit;
  logic       tx;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         starts[$];
  bit         in_frame = 1'b0;

  risc8_uart_tx #(
    .BAUD_DIV   (BAUD),
    .FIFO_DEPTH (4),
    .DATA_ADDR  (A_DATA),
    .STAT_ADDR  (A_STAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .rd_data     (rd_data),
    .rd_hit      (rd_hit),
    .tx          (tx)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line monitor: one sample per cycle, compared against the expected bit of the frame.
  initial begin
    int         off;
    int         b;
    logic [7:0] eb;
    logic       ebit;
    off = 0;
    eb = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_frame = 1'b0;
      end else begin
        if (!in_frame && tx === 1'b0) begin
          in_frame = 1'b1;
          off = 0;
          starts.push_back(cyc);
          check("frame_expected", 16'(exp_q.size() != 0), 16'd1);
          eb = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        end
        if (in_frame) begin
          b = off / BAUD;
          if (b == 0)                         ebit = 1'b0;
          else if (b <= 8)                    ebit = eb[b-1];
          else if (b == 9 && FRAME_BITS == 11) ebit = ^eb;
          else                                ebit = 1'b1;
          check($sformatf("frame%0d_byte%02h_bit%0d", starts.size(), eb, b),
                16'(tx), 16'(ebit));
          off++;
          if (off == FRAME_CYC) in_frame = 1'b0;
        end
      end
    end
  end

  task automatic store(input logic [7:0] addr, input logic [7:0] data, input bit expect_tx);
    @(negedge clk);
    mem_addr    = addr;
    mem_wr_data = data;
    mem_wr_en   = 1'b1;
    if (expect_tx) exp_q.push_back(data);
    @(posedge clk);
    #1;
    mem_wr_en = 1'b0;
    mem_addr  = 8'h00;
  endtask

  task automatic rd_stat(input string tag, input logic [7:0] exp);
    mem_addr = A_STAT;
    #1;
    check(tag, 16'(rd_data), 16'(exp));
    mem_addr = 8'h00;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    check(tag, 16'(n < max_cyc), 16'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int s0;
    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_held", 16'(tx), 16'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_tx", 16'(tx), 16'd1);
    rd_stat("rst_status", 8'h04);
    mem_addr = A_STAT; #1; check("hit_stat", 16'(rd_hit), 16'd1);
    mem_addr = A_DATA; #1; check("hit_data", 16'(rd_hit), 16'd1);
    check("rd_data_at_data", 16'(rd_data), 16'd0);
    mem_addr = 8'h00;  #1; check("hit_00", 16'(rd_hit), 16'd0);
    mem_addr = 8'hFD;  #1; check("hit_fd", 16'(rd_hit), 16'd0);
    mem_addr = 8'h00;

    // Single byte
    store(A_DATA, 8'hA5, 1'b1);
    check("sb_tx_at_e0", 16'(tx), 16'd1);
    rd_stat("sb_status_e0", 8'h10);
    @(posedge clk);
    #1;
    check("sb_tx_fall_e1", 16'(tx), 16'd0);
    rd_stat("sb_status_e1", 8'h05);
    repeat (FRAME_CYC - 1) @(posedge clk);
    #1;
    rd_stat("sb_busy_last", 8'h05);
    @(posedge clk);
    #1;
    rd_stat("sb_idle_after", 8'h04);
    drain("sb_drain", 100);

    // Back-to-back
    s0 = starts.size();
    store(A_DATA, 8'h00, 1'b1);
    store(A_DATA, 8'hFF, 1'b1);
    drain("b2b_drain", 3 * FRAME_CYC);
    check("b2b_frames", 16'(starts.size() - s0), 16'd2);
    if (starts.size() - s0 == 2)
      check("b2b_gap", 16'(starts[s0+1] - starts[s0]), 16'(FRAME_CYC));
    rd_stat("b2b_status_end", 8'h04);

    // Overflow
    s0 = starts.size();
    for (int i = 0; i < 6; i++) store(A_DATA, 8'h11 + 8'(i), i < 5);
    rd_stat("ovf_status", 8'h4B);
    store(A_STAT, 8'hAA, 1'b0);
    rd_stat("ovf_cleared", 8'h43);
    drain("ovf_drain", 6 * FRAME_CYC);
    check("ovf_frames", 16'(starts.size() - s0), 16'd5);
    rd_stat("ovf_status_end", 8'h04);

    // Reset mid-frame, during data bit 3
    s0 = starts.size();
    store(A_DATA, 8'h3C, 1'b1);
    store(A_DATA, 8'h5A, 1'b0);
    store(A_DATA, 8'hC3, 1'b0);
    repeat (16) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_tx", 16'(tx), 16'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rd_stat("mid_rst_status", 8'h04);
    repeat (100) @(posedge clk);
    #1;
    check("mid_rst_frames", 16'(starts.size() - s0), 16'd1);
    check("mid_rst_queue", 16'(exp_q.size()), 16'd0);
    check("mid_rst_tx_idle", 16'(tx), 16'd1);

    // Parity-sensitive byte (parity bit checked by the monitor in the parity build)
    s0 = starts.size();
    store(A_DATA, 8'h07, 1'b1);
    drain("p_drain", 2 * FRAME_CYC);
    check("p_frames", 16'(starts.size() - s0), 16'd1);
    rd_stat("p_status_end", 8'h04);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/risc8_uart_tx.md
# risc8_uart_tx

Memory-mapped serial transmitter sitting directly downstream of the risc8 CPU data-memory port, alongside system RAM. It snoops CPU stores, queues bytes written to the data register in a small FIFO, and shifts them out as 8N1 UART frames. It also exposes a combinational status register for CPU polling.

## Interface
- `BAUD_DIV`, 434: clock cycles per serial bit; legal range 2..65535.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, 2..8.
- `DATA_ADDR`, 8'hFF: store address that enqueues a byte.
- `STAT_ADDR`, 8'hFE: status address; a store here clears overflow.
- `clk  in  1`: system clock, shared with the CPU.
- `rst  in  1`: asynchronous, active-low reset (asserted at 0).
- `mem_addr  in  8`: CPU data address (`word`).
- `mem_wr_en  in  1`: CPU store strobe.
- `mem_wr_data  in  8`: CPU store data.
- `rd_data  out  8`: read data for the CPU read mux.
- `rd_hit  out  1`: high when `mem_addr` equals `DATA_ADDR` or `STAT_ADDR`; the top level selects `rd_data` over RAM.
- `tx  out  1`: serial line, idle high.

## Operation
- **Enqueue:** `mem_wr_en && mem_addr==DATA_ADDR` at a rising edge with FIFO not full stores `mem_wr_data`.
- **Overflow:** an enqueue attempt while full drops the byte and sets sticky `ovf`.
- **Overflow clear:** a store to `STAT_ADDR` clears `ovf`; the data value is ignored.
- **Clear vs. new overflow:** a clear and a new overflow never coincide, since only one address is written per cycle.
- **Status byte:** [0] busy (FSM not IDLE), [1] full, [2] empty, [3] ovf, [7:4] FIFO count.
- **Read data:** `rd_data` = status when `mem_addr==STAT_ADDR`, and 8'h00 otherwise (DATA_ADDR reads return 0).
- **FSM states:** IDLE, START, DATA, STOP (PARITY when configured).
- **IDLE:** if FIFO not empty, pop into shift register, load bit counter 0, go to START.
- **START:** `tx`=0 for `BAUD_DIV` cycles, then go to DATA.
- **DATA:** shift out LSB first, `BAUD_DIV` cycles per bit. After bit 7, go to STOP (or PARITY).
- **STOP:** `tx`=1 for `BAUD_DIV` cycles. At its end, if FIFO is not empty, pop and go straight to START with no idle gap; otherwise go to IDLE.
- **Baud counter:** 16-bit, counts `BAUD_DIV-1` down to 0, reloaded on every state/bit change.
- **Simultaneous push and pop:**
  - Full FIFO: push accepted, count unchanged.
  - Empty FIFO: the byte is not visible to the pop in the same cycle; it is popped next cycle.
- **FIFO pointers:** wrap modulo `FIFO_DEPTH`. The count is a separate register, width clog2(`FIFO_DEPTH`)+1.

## Timing
- **Reset values:** `tx`=1, FSM=IDLE, FIFO empty (count 0), `ovf`=0, shift register 0.
- **Combinational outputs:** `rd_data`/`rd_hit` are combinational from `mem_addr` and registered state. On reset they show status 8'h04 at `STAT_ADDR`.
- **Latency:** a store accepted at edge E0 makes the FIFO non-empty after E0. The pop occurs at E1, and `tx` falls after E1.
- **Frame length:** 10·`BAUD_DIV` cycles, or 11·`BAUD_DIV` with parity. Back-to-back frames are contiguous.
- **Status visibility:** busy goes high after E1 and stays high until the STOP→IDLE edge.
- **Reset mid-frame:** `tx` returns to 1 asynchronously, the frame is truncated, and queued bytes are lost.

## Configuration
- **`RISC8_UART_PARITY_EN` defined:** a PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the 8 data bits) for `BAUD_DIV` cycles.
- **`RISC8_UART_PARITY_EN` undefined:** no PARITY state exists; frames are 8N1.
- Status bit layout is identical in both builds.

## Structure
- **`risc_pkg`:**
  - `UART_DATA_ADDR`/`UART_STAT_ADDR` defaults.
  - Status bit index constants (`UST_BUSY`, `UST_FULL`, `UST_EMPTY`, `UST_OVF`).
  - `e_uart_state` enum.
- **Sub-module `risc8_sync_fifo`:** parameterised width/depth, push/pop/full/empty/count, asynchronous active-low reset. The FSM, baud counter and address decode stay in `risc8_uart_tx`.

## Test plan
All scenarios use `BAUD_DIV`=4 and `FIFO_DEPTH`=4.
- **Reset:** hold `rst`=0, then release → `tx`=1; status reads 8'h04; `rd_hit`=1 only at 8'hFE/8'hFF.
- **Single byte:** store 8'hA5 to 8'hFF → `tx` falls one cycle after the store edge. Line shows 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), 4 cycles each, 40 cycles total, then busy=0.
- **Back-to-back:** store 8'h00 then 8'hFF on consecutive cycles → two contiguous 40-cycle frames with no idle cycle between the stop bit and the second start bit.
- **Overflow:**
  - Store 6 bytes in 6 consecutive cycles → 1 popped, 4 queued, 6th dropped; status = 8'h4B (count 4, ovf, full, busy).
  - Store to 8'hFE → ovf=0.
  - Drain → only the first 5 bytes appear on `tx`.
- **Reset mid-frame:** assert `rst` during data bit 3 → `tx`=1 in the same cycle; status 8'h04 after release; no further frames.
- **Parity build (macro defined):** send 8'h07 → parity bit 1; frame is 44 cycles.
